// File: rtl/uart_tx_core.sv
// UART transmit engine: shifts out start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Runs on a baud-rate clock, one line bit per clk_TX cycle.
module uart_tx_core #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_TX,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CntW-1:0]       bit_cnt;
  logic                  par_en_reg;
  logic                  par_bit;

  // Outputs are registered from the current state, so the line lags the state by one cycle.
  always_ff @(posedge clk_TX or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      par_en_reg <= 1'b0;
      par_bit    <= 1'b0;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          if (Data_Valid) begin
            shift_reg  <= P_DATA;
            par_en_reg <= PAR_EN;
            par_bit    <= (^P_DATA) ^ PAR_TYP;
            state      <= StStart;
          end
        end
        StStart: begin
          TX_OUT  <= 1'b0;
          busy    <= 1'b1;
          bit_cnt <= '0;
          state   <= StData;
        end
        StData: begin
          TX_OUT    <= shift_reg[0];
          busy      <= 1'b1;
          shift_reg <= shift_reg >> 1;
          if (bit_cnt == LastBit) begin
            state <= par_en_reg ? StParity : StStop;
          end else begin
            bit_cnt <= bit_cnt + CntW'(1);
          end
        end
        StParity: begin
          TX_OUT <= par_bit;
          busy   <= 1'b1;
          state  <= StStop;
        end
        StStop: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b1;
          // Accepting here chains the next frame with no idle gap.
          if (Data_Valid) begin
            shift_reg  <= P_DATA;
            par_en_reg <= PAR_EN;
            par_bit    <= (^P_DATA) ^ PAR_TYP;
            state      <= StStart;
          end else begin
            state <= StIdle;
          end
        end
        default: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          state  <= StIdle;
        end
      endcase
    end
  end

endmodule
